// File: rtl/sdram_test_pkg.sv
// Shared definitions for the key-triggered SDRAM self-test sequencer:
// FSM state encoding, default geometry/timeout and the error-count ceiling.
package sdram_test_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_DATA,
      S_RD_REQ,
      S_RD_DATA,
      S_DONE
   } state_t;

   localparam int          DEF_BURST_LEN  = 8;
   localparam int          DEF_N_BURSTS   = 4;
   localparam int          DEF_RD_TIMEOUT = 1024;
   localparam logic [15:0] ERR_SAT        = 16'hFFFF;

endpackage

// File: rtl/sdram_test_pat.sv
// Test pattern generator: data(i) = (run_id << 8) + i, modulo 2^DATA_W.
// Purely combinational so the write and read sides stay bit-identical.
module sdram_test_pat #(
   parameter int DATA_W = 16
) (
   input  logic [7:0]        run_id,
   input  logic [15:0]       idx,
   output logic [DATA_W-1:0] data
);

   assign data = DATA_W'({run_id, 8'h00}) + DATA_W'(idx);

endmodule

// File: rtl/sdram_key_test.sv
// Key-triggered SDRAM self-test: writes N_BURSTS bursts of a run-specific
// pattern, reads them back, compares every word and reports the result.
module sdram_key_test
   import sdram_test_pkg::*;
#(
   parameter int                ADDR_W     = 24,
   parameter int                DATA_W     = 16,
   parameter int                BURST_LEN  = DEF_BURST_LEN,
   parameter int                N_BURSTS   = DEF_N_BURSTS,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter int                RD_TIMEOUT = DEF_RD_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_vld,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_ack,
   input  logic              wr_data_en,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_ack,
   input  logic              rd_data_vld,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_cnt,
   output logic [7:0]        run_id
);

   localparam int WD_W = $clog2(RD_TIMEOUT + 1);

   state_t            state, state_next;
   logic [7:0]        burst, burst_next, beat;
   logic [15:0]       word_idx, err_next;
   logic [WD_W-1:0]   wd_cnt;
   logic              cmp_vld, cmp_err;
   logic              start, wr_beat, rd_beat, last_beat, last_burst, timeout;
   logic [7:0]        pat_run;
   logic [15:0]       pat_idx;
   logic [DATA_W-1:0] wr_pat, rd_pat;

   function automatic logic [ADDR_W-1:0] burst_addr(input logic [7:0] b);
      return BASE_ADDR + ADDR_W'(32'(b) * 32'(BURST_LEN));
   endfunction

   always_comb begin
      start      = (state == S_IDLE) && key_vld;
      wr_beat    = (state == S_WR_DATA) && wr_data_en;
      rd_beat    = (state == S_RD_DATA) && rd_data_vld;
      last_beat  = (beat == 8'(BURST_LEN - 1));
      last_burst = (burst == 8'(N_BURSTS - 1));
      timeout    = (state == S_RD_DATA) && (wd_cnt == WD_W'(RD_TIMEOUT - 1))
                   && !(rd_beat && last_beat);
   end

   // NOTE: sequential state is written with <= only; every always_comb
   // assigns a default first so no latch can be inferred.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (start) state_next = S_WR_REQ;
         S_WR_REQ:  if (wr_ack) state_next = S_WR_DATA;
         S_WR_DATA: if (wr_beat && last_beat) state_next = last_burst ? S_RD_REQ : S_WR_REQ;
         S_RD_REQ:  if (rd_ack) state_next = S_RD_DATA;
         S_RD_DATA: begin
            if (rd_beat && last_beat) state_next = last_burst ? S_DONE : S_RD_REQ;
            else if (timeout)         state_next = S_DONE;
         end
         // Hold DONE until the last registered compare has landed in err_cnt.
         S_DONE:    if (!cmp_vld) state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   always_comb begin
      wr_req = (state == S_WR_REQ);
      rd_req = (state == S_RD_REQ);
      busy   = (state != S_IDLE);
      done   = (state == S_DONE) && !cmp_vld;
   end

   always_comb begin
      burst_next = burst;
      if (start)
         burst_next = '0;
      else if ((wr_beat || rd_beat) && last_beat)
         burst_next = last_burst ? 8'd0 : burst + 8'd1;
   end

   always_comb begin
      err_next = err_cnt;
      if (start)
         err_next = '0;
      else if (timeout)
         err_next = ERR_SAT;
      else if (cmp_vld && cmp_err && (err_cnt != ERR_SAT))
         err_next = err_cnt + 16'd1;
   end

   // The write word is pre-loaded: first word at start, next word on each beat.
   always_comb begin
      pat_run = start ? run_id + 8'd1 : run_id;
      pat_idx = start ? 16'd0 : word_idx + 16'd1;
   end

   sdram_test_pat #(.DATA_W(DATA_W)) u_wr_pat (.run_id(pat_run), .idx(pat_idx),  .data(wr_pat));
   sdram_test_pat #(.DATA_W(DATA_W)) u_rd_pat (.run_id(run_id),  .idx(word_idx), .data(rd_pat));

   always_ff @(posedge clk) begin
      if (rst) begin
         burst    <= '0;
         beat     <= '0;
         word_idx <= '0;
         wd_cnt   <= '0;
         cmp_vld  <= 1'b0;
         cmp_err  <= 1'b0;
         err_cnt  <= '0;
         run_id   <= '0;
         pass     <= 1'b0;
         wr_data  <= '0;
         wr_addr  <= '0;
         rd_addr  <= '0;
      end else begin
         burst   <= burst_next;
         err_cnt <= err_next;
         cmp_vld <= rd_beat;
         cmp_err <= rd_beat && (rd_data != rd_pat);
         if (start) run_id <= run_id + 8'd1;
         if (start || wr_beat) wr_data <= wr_pat;

         if (start || (wr_beat && last_beat && last_burst)) word_idx <= '0;
         else if (wr_beat || rd_beat)                       word_idx <= word_idx + 16'd1;

         if ((state == S_WR_REQ && wr_ack) || (state == S_RD_REQ && rd_ack)) beat <= '0;
         else if (wr_beat || rd_beat)                                         beat <= beat + 8'd1;

         if (state == S_RD_REQ && rd_ack) wd_cnt <= '0;
         else if (state == S_RD_DATA)     wd_cnt <= wd_cnt + 1'b1;

         if (state_next == S_WR_REQ && state != S_WR_REQ) wr_addr <= burst_addr(burst_next);
         if (state_next == S_RD_REQ && state != S_RD_REQ) rd_addr <= burst_addr(burst_next);

         // Latch the verdict on the edge that leads into the done pulse.
         if (state_next == S_DONE && !rd_beat) pass <= (err_next == '0);
      end
   end

endmodule

// File: tb/tb_sdram_key_test.sv
// Self-checking bench for sdram_key_test: behavioural SDRAM controller with a
// word memory, result scoreboard popped on each done pulse.
module tb_sdram_key_test;

   localparam int T_OUT = 64;
   localparam int BL    = 8;
   localparam int NB    = 4;

   logic        clk = 1'b0;
   logic        rst, key_vld;
   logic        wr_req, wr_ack, wr_data_en, rd_req, rd_ack, rd_data_vld;
   logic [23:0] wr_addr, rd_addr;
   logic [15:0] wr_data, rd_data, err_cnt;
   logic        busy, done, pass;
   logic [7:0]  run_id;

   sdram_key_test #(
      .ADDR_W(24), .DATA_W(16), .BURST_LEN(BL), .N_BURSTS(NB),
      .BASE_ADDR(24'd0), .RD_TIMEOUT(T_OUT)
   ) dut (
      .clk(clk), .rst(rst), .key_vld(key_vld),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
      .wr_data_en(wr_data_en), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
      .rd_data_vld(rd_data_vld), .rd_data(rd_data),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .run_id(run_id)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  run;
      logic [15:0] err;
      logic        pss;
      logic        to;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0, n_err = 0;
   int          cyc = 0;
   logic [7:0]  exp_run = 8'd0;
   logic [15:0] mem [256];
   int          ctl_wb = 0, ctl_rb = 0;
   int          gap_max = 0;
   bit          flip = 1'b0, stall_rd = 1'b0;
   int          last_rd_cyc = 0, rd_ack_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Behavioural controller: acks requests, moves beats with random gaps.
   typedef enum int {C_IDLE, C_WB, C_RB, C_STALL} ctl_t;
   initial begin
      ctl_t c_state = C_IDLE;
      int   beat = 0, gap = 0, idx;
      wr_ack = 0; wr_data_en = 0; rd_ack = 0; rd_data_vld = 0; rd_data = '0;
      forever begin
         @(negedge clk);
         wr_ack = 0; wr_data_en = 0; rd_ack = 0; rd_data_vld = 0;
         if (rst) begin
            c_state = C_IDLE;
         end else begin
            case (c_state)
               C_IDLE: begin
                  if (wr_req) begin
                     chk("wr_addr", wr_addr, ctl_wb * BL);
                     wr_ack = 1; beat = 0; gap = $urandom_range(gap_max, 0);
                     c_state = C_WB;
                  end else if (rd_req) begin
                     chk("rd_addr", rd_addr, ctl_rb * BL);
                     rd_ack = 1; beat = 0; gap = $urandom_range(gap_max, 0);
                     rd_ack_cyc = cyc;
                     c_state = stall_rd ? C_STALL : C_RB;
                  end
               end
               C_WB: begin
                  if (gap > 0) gap--;
                  else begin
                     idx = ctl_wb * BL + beat;
                     chk("wr_data", wr_data, 16'((int'(exp_run) << 8) + idx));
                     mem[idx & 255] = wr_data;
                     wr_data_en = 1; beat++; gap = $urandom_range(gap_max, 0);
                     if (beat == BL) begin ctl_wb++; c_state = C_IDLE; end
                  end
               end
               C_RB: begin
                  if (gap > 0) gap--;
                  else begin
                     idx = ctl_rb * BL + beat;
                     rd_data = mem[idx & 255] ^ {15'd0, flip && (idx == 5 || idx == 17)};
                     rd_data_vld = 1; beat++; gap = $urandom_range(gap_max, 0);
                     if (beat == BL) begin
                        if (ctl_rb == NB - 1) last_rd_cyc = cyc;
                        ctl_rb++; c_state = C_IDLE;
                     end
                  end
               end
               C_STALL: if (!busy) c_state = C_IDLE;
               default: c_state = C_IDLE;
            endcase
         end
      end
   end

   // Result monitor: every done pulse must match the oldest expected pass.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && done) begin
            if (sb.size() == 0) chk("done_unexpected", {31'd0, done}, 0);
            else begin
               e = sb.pop_front();
               chk("run_id", run_id, e.run);
               chk("err_cnt", err_cnt, e.err);
               chk("pass", pass, e.pss);
               if (e.to) chk("timeout_latency", cyc - rd_ack_cyc, T_OUT + 1);
               else      chk("done_latency", cyc - last_rd_cyc, 2);
               @(negedge clk);
               chk("done_one_cycle", done, 0);
               chk("busy_clear", busy, 0);
            end
         end
      end
   end

   task automatic press();
      @(negedge clk); key_vld = 1;
      @(negedge clk); key_vld = 0;
   endtask

   task automatic start_pass(input logic [7:0] run, input logic [15:0] err,
                             input logic pss, input logic to);
      exp_t e;
      e.run = run; e.err = err; e.pss = pss; e.to = to;
      exp_run = run; ctl_wb = 0; ctl_rb = 0;
      sb.push_back(e);
      press();
      chk("key_wr_req", wr_req, 1);
      chk("key_busy", busy, 1);
   endtask

   task automatic wait_results(input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin @(negedge clk); k++; end
      chk("pending_results", sb.size(), 0);
      sb.delete();
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_beat(input bit rd);
      int k = 0;
      do begin @(posedge clk); k++; end
      while (!(rd ? rd_data_vld : wr_data_en) && k < 1000);
      chk(rd ? "saw_rd_beat" : "saw_wr_beat", rd ? rd_data_vld : wr_data_en, 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_wr_req"}, wr_req, 0);
      chk({tag, "_rd_req"}, rd_req, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_wr_data"}, wr_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_err_cnt"}, err_cnt, 0);
      chk({tag, "_run_id"}, run_id, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1; key_vld = 0;
      repeat (3) @(negedge clk);
      chk_reset("por");
      rst = 0;
      repeat (2) @(negedge clk);

      // Ideal controller, clean memory.
      start_pass(8'd1, 16'd0, 1'b1, 1'b0);
      wait_results(2000);

      // Bit 0 of words 5 and 17 corrupted on read.
      flip = 1;
      start_pass(8'd2, 16'd2, 1'b0, 1'b0);
      wait_results(2000);
      flip = 0;

      // Extra key presses mid-pass are ignored.
      start_pass(8'd3, 16'd0, 1'b1, 1'b0);
      wait_beat(1'b0);
      press();
      chk("run_id_hold_wr", run_id, 3);
      wait_beat(1'b1);
      press();
      chk("run_id_hold_rd", run_id, 3);
      wait_results(2000);

      // Read port never returns data: watchdog ends the pass.
      stall_rd = 1;
      start_pass(8'd4, 16'hFFFF, 1'b0, 1'b1);
      wait_results(2000);
      stall_rd = 0;

      // Gapped beats, then a reset in the middle of the read phase.
      gap_max = 3;
      start_pass(8'd5, 16'd0, 1'b1, 1'b0);
      wait_results(3000);
      start_pass(8'd6, 16'd0, 1'b1, 1'b0);
      wait_beat(1'b1);
      @(negedge clk); rst = 1;
      @(negedge clk);
      @(negedge clk);
      chk_reset("mid_rst");
      rst = 0;
      void'(sb.pop_back());
      repeat (2) @(negedge clk);
      start_pass(8'd1, 16'd0, 1'b1, 1'b0);
      wait_results(3000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
